exe_stage: RTL and testbench

- Execute stage of the five-stage in-order LoongArch32 pipeline, between decode (ds) and memory (ms).
- Latches the decode bundle and computes the ALU result through a sub-module.
- Checks load/store address alignment, formats store data and strobes, and issues requests on the sram-like data port (req/addr_ok).
- Holds the 64-bit stable counter for rdcntvl.w/rdcntvh.w and emits the 144-bit es_to_ms_bus that ms consumes.

---
 rtl/exe_stage_pkg.sv | 100 ++++++++++
 rtl/exe_stage_if.sv | 13 +
 rtl/exe_stage_alu.sv | 58 +++++
 rtl/exe_stage.sv | 129 ++++++++++++
 tb/tb_exe_stage.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus layouts, op encodings,
// exception cause indices and data-port size codes.
package exe_stage_pkg;

    localparam int DS_ES_W = 231;
    localparam int ES_MS_W = 144;
    localparam int EXC_W   = 17;

    // ld_op / st_op one-hot bit positions
    localparam int LD_B  = 0;
    localparam int LD_BU = 1;
    localparam int LD_H  = 2;
    localparam int LD_HU = 3;
    localparam int LD_W  = 4;
    localparam int ST_B  = 0;
    localparam int ST_H  = 1;
    localparam int ST_W  = 2;

    // alu_op one-hot bit positions
    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_SLT   = 2;
    localparam int ALU_SLTU  = 3;
    localparam int ALU_AND   = 4;
    localparam int ALU_NOR   = 5;
    localparam int ALU_OR    = 6;
    localparam int ALU_XOR   = 7;
    localparam int ALU_SLL   = 8;
    localparam int ALU_SRL   = 9;
    localparam int ALU_SRA   = 10;
    localparam int ALU_LUI   = 11;
    localparam int ALU_MUL   = 12;
    localparam int ALU_MULH  = 13;
    localparam int ALU_MULHU = 14;
    localparam int ALU_DIV   = 15;
    localparam int ALU_MOD   = 16;
    localparam int ALU_DIVU  = 17;
    localparam int ALU_MODU  = 18;

    // ex_cause bit indices
    localparam int EXC_INT  = 0;
    localparam int EXC_ADEF = 1;
    localparam int EXC_ALE  = 2;
    localparam int EXC_SYS  = 3;
    localparam int EXC_BRK  = 4;
    localparam int EXC_INE  = 5;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      src1;
        logic [31:0]      src2;
        logic [18:0]      alu_op;
        logic [31:0]      rkd_value;
        logic [4:0]       ld_op;
        logic [2:0]       st_op;
        logic             res_from_mem;
        logic             gr_we;
        logic [4:0]       dest;
        logic             csr_we;
        logic             csr_rd;
        logic             ertn;
        logic             rdcntid;
        logic             rdcntvl;
        logic             rdcntvh;
        logic [31:0]      csr_wmask;
        logic [13:0]      csr_num;
        logic [EXC_W-1:0] ex_cause;
    } ds_es_bus_t;

    typedef struct packed {
        logic             mem_we;
        logic             rdcntid;
        logic             ertn;
        logic             csr_we;
        logic             csr_rd;
        logic [31:0]      csr_wmask;
        logic [13:0]      csr_num;
        logic [EXC_W-1:0] ex_cause;
        logic [4:0]       ld_op;
        logic             res_from_mem;
        logic             gr_we;
        logic [4:0]       dest;
        logic [31:0]      result;
        logic [31:0]      pc;
    } es_ms_bus_t;

    function automatic logic [1:0] mem_size(input logic [4:0] ld_op, input logic [2:0] st_op);
        if (ld_op[LD_W] || st_op[ST_W])
            return SIZE_WORD;
        else if (ld_op[LD_H] || ld_op[LD_HU] || st_op[ST_H])
            return SIZE_HALF;
        else
            return SIZE_BYTE;
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Sram-like data port between the execute stage (master) and data memory (slave).
interface exe_stage_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;

    modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok);
    modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok);
endinterface

// File: rtl/exe_stage_alu.sv
// Combinational ALU with a 19-bit one-hot operation select.
module exe_stage_alu
    import exe_stage_pkg::*;
(
    input  logic [18:0] alu_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] result
);

    logic [31:0]        sum, diff, sra_res;
    logic signed [32:0] m1, m2;
    logic [63:0]        prod;
    logic [31:0]        quo_s, rem_s, quo_u, rem_u;
    logic               div_zero;

    assign sum  = src1 + src2;
    assign diff = src1 - src2;
    assign sra_res = $signed(src1) >>> src2[4:0];

    // One 33x33 signed multiplier serves signed and unsigned high products
    assign m1   = {alu_op[ALU_MULH] & src1[31], src1};
    assign m2   = {alu_op[ALU_MULH] & src2[31], src2};
    assign prod = 64'(m1) * 64'(m2);

    assign div_zero = (src2 == 32'd0);
    assign quo_s = div_zero ? 32'd0 : $signed(src1) / $signed(src2);
    assign rem_s = div_zero ? 32'd0 : $signed(src1) % $signed(src2);
    assign quo_u = div_zero ? 32'd0 : src1 / src2;
    assign rem_u = div_zero ? 32'd0 : src1 % src2;

    always_comb begin
        result = 32'd0;
        case (1'b1)
            alu_op[ALU_ADD]:   result = sum;
            alu_op[ALU_SUB]:   result = diff;
            alu_op[ALU_SLT]:   result = {31'd0, $signed(src1) < $signed(src2)};
            alu_op[ALU_SLTU]:  result = {31'd0, src1 < src2};
            alu_op[ALU_AND]:   result = src1 & src2;
            alu_op[ALU_NOR]:   result = ~(src1 | src2);
            alu_op[ALU_OR]:    result = src1 | src2;
            alu_op[ALU_XOR]:   result = src1 ^ src2;
            alu_op[ALU_SLL]:   result = src1 << src2[4:0];
            alu_op[ALU_SRL]:   result = src1 >> src2[4:0];
            alu_op[ALU_SRA]:   result = sra_res;
            alu_op[ALU_LUI]:   result = src2;
            alu_op[ALU_MUL]:   result = prod[31:0];
            alu_op[ALU_MULH],
            alu_op[ALU_MULHU]: result = prod[63:32];
            alu_op[ALU_DIV]:   result = quo_s;
            alu_op[ALU_MOD]:   result = rem_s;
            alu_op[ALU_DIVU]:  result = quo_u;
            alu_op[ALU_MODU]:  result = rem_u;
            default:           result = 32'd0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bundle, runs the ALU, issues data-port
// requests with alignment checking, and owns the 64-bit stable counter.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ms_allowin,
    output logic               es_allowin,
    input  logic               ds_to_es_valid,
    input  logic [DS_ES_W-1:0] ds_to_es_bus,
    output logic               es_to_ms_valid,
    output logic [ES_MS_W-1:0] es_to_ms_bus,
    exe_stage_if.master        data_sram,
    output logic [4:0]         es_to_ds_dest,
    output logic [31:0]        es_to_ds_value,
    output logic               es_load,
    output logic               es_csr,
    output logic               es_tid,
    input  logic               ms_int,
    input  logic               ws_int,
    input  logic               ws_reflush_es
);

    ds_es_bus_t       bus_r;
    es_ms_bus_t       ms_bus;
    logic             es_valid;
    logic             es_ready_go;
    logic [63:0]      stable_cnt;
    logic [31:0]      alu_result, es_result, addr;
    logic             mem_op, is_store, is_half, is_word, ale, es_ex, cancel;
    logic [EXC_W-1:0] ex_cause_out;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            es_valid <= 1'b0;
        else if (ws_reflush_es)
            es_valid <= 1'b0;
        else if (es_allowin)
            es_valid <= ds_to_es_valid;
    end

    // NOTE: bus_r carries no reset; es_valid qualifies every observable use of it.
    always_ff @(posedge clk) begin
        if (ds_to_es_valid && es_allowin)
            bus_r <= ds_to_es_bus;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stable_cnt <= 64'd0;
        else
            stable_cnt <= stable_cnt + 64'd1;
    end

    exe_stage_alu u_alu (
        .alu_op (bus_r.alu_op),
        .src1   (bus_r.src1),
        .src2   (bus_r.src2),
        .result (alu_result)
    );

    assign addr     = alu_result;
    assign is_store = |bus_r.st_op;
    assign mem_op   = (|bus_r.ld_op) || is_store;
    assign is_half  = bus_r.ld_op[LD_H] || bus_r.ld_op[LD_HU] || bus_r.st_op[ST_H];
    assign is_word  = bus_r.ld_op[LD_W] || bus_r.st_op[ST_W];
    assign ale      = es_valid && mem_op &&
                      ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)));

    assign ex_cause_out = bus_r.ex_cause | (EXC_W'(ale) << EXC_ALE);
    assign es_ex        = (|ex_cause_out) || bus_r.ertn;
    assign cancel       = es_ex || ms_int || ws_int || ws_reflush_es;

    // Request only when ms can take it, so an accepted request enters ms this cycle
    assign data_sram.req  = es_valid && mem_op && !cancel && ms_allowin;
    assign data_sram.wr   = is_store;
    assign data_sram.size = mem_size(bus_r.ld_op, bus_r.st_op);
    assign data_sram.addr = addr;

    assign es_ready_go    = !(mem_op && !cancel) || (data_sram.req && data_sram.addr_ok);
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go && !ws_reflush_es;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        data_sram.wstrb = 4'b0000;
        data_sram.wdata = bus_r.rkd_value;
        if (bus_r.st_op[ST_B]) begin
            data_sram.wstrb = 4'b0001 << addr[1:0];
            data_sram.wdata = {4{bus_r.rkd_value[7:0]}};
        end else if (bus_r.st_op[ST_H]) begin
            data_sram.wstrb = addr[1] ? 4'b1100 : 4'b0011;
            data_sram.wdata = {2{bus_r.rkd_value[15:0]}};
        end else if (bus_r.st_op[ST_W]) begin
            data_sram.wstrb = 4'b1111;
        end
    end

    assign es_result = bus_r.rdcntvl ? stable_cnt[31:0]  :
                       bus_r.rdcntvh ? stable_cnt[63:32] : alu_result;

    // mem_we/res_from_mem are cleared on cancel so ms never waits on an unissued request
    always_comb begin
        ms_bus.mem_we       = is_store && !cancel;
        ms_bus.rdcntid      = bus_r.rdcntid;
        ms_bus.ertn         = bus_r.ertn;
        ms_bus.csr_we       = bus_r.csr_we;
        ms_bus.csr_rd       = bus_r.csr_rd;
        ms_bus.csr_wmask    = bus_r.csr_wmask;
        ms_bus.csr_num      = bus_r.csr_num;
        ms_bus.ex_cause     = ex_cause_out;
        ms_bus.ld_op        = bus_r.ld_op;
        ms_bus.res_from_mem = bus_r.res_from_mem && !cancel;
        ms_bus.gr_we        = bus_r.gr_we;
        ms_bus.dest         = bus_r.dest;
        ms_bus.result       = es_result;
        ms_bus.pc           = bus_r.pc;
    end

    assign es_to_ms_bus   = ms_bus;
    assign es_to_ds_dest  = (es_valid && bus_r.gr_we) ? bus_r.dest : 5'd0;
    assign es_to_ds_value = (es_valid && bus_r.gr_we) ? es_result  : 32'd0;
    assign es_load        = es_valid && (|bus_r.ld_op);
    assign es_csr         = es_valid && (bus_r.csr_we || bus_r.csr_rd);
    assign es_tid         = es_valid && bus_r.rdcntid;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: data-port handshake, store formatting,
// alignment exceptions, cancellation, flush and the stable counter.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               ms_allowin;
    logic               es_allowin;
    logic               ds_to_es_valid;
    logic [DS_ES_W-1:0] ds_to_es_bus;
    logic               es_to_ms_valid;
    logic [ES_MS_W-1:0] es_to_ms_bus;
    logic [4:0]         es_to_ds_dest;
    logic [31:0]        es_to_ds_value;
    logic               es_load, es_csr, es_tid;
    logic               ms_int, ws_int, ws_reflush_es;
    logic [63:0]        cyc;
    int                 checks = 0;
    int                 errors = 0;

    // decode bundle fields, packed MSB-first into ds_to_es_bus by drive_bus
    logic [31:0] f_pc, f_src1, f_src2, f_rkd, f_wmask;
    logic [18:0] f_alu_op;
    logic [4:0]  f_ld, f_dest;
    logic [2:0]  f_st;
    logic        f_rfm, f_gwe, f_csr_we, f_csr_rd, f_ertn, f_tid, f_cvl, f_cvh;
    logic [13:0] f_num;
    logic [16:0] f_exc;

    always #5 clk = ~clk;

    exe_stage_if sram_if ();

    exe_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ms_allowin     (ms_allowin),
        .es_allowin     (es_allowin),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .data_sram      (sram_if),
        .es_to_ds_dest  (es_to_ds_dest),
        .es_to_ds_value (es_to_ds_value),
        .es_load        (es_load),
        .es_csr         (es_csr),
        .es_tid         (es_tid),
        .ms_int         (ms_int),
        .ws_int         (ws_int),
        .ws_reflush_es  (ws_reflush_es)
    );

    // reference cycle count, started by the same synchronous reset as the DUT counter
    always @(posedge clk) begin
        if (reset) cyc <= 64'd0;
        else       cyc <= cyc + 64'd1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fields();
        f_pc = 32'h1c00_0100; f_src1 = '0; f_src2 = '0; f_rkd = '0; f_wmask = '0;
        f_alu_op = 19'd1 << ALU_ADD; f_ld = '0; f_dest = '0; f_st = '0;
        f_rfm = 0; f_gwe = 0; f_csr_we = 0; f_csr_rd = 0; f_ertn = 0;
        f_tid = 0; f_cvl = 0; f_cvh = 0; f_num = '0; f_exc = '0;
    endtask

    task automatic drive_bus();
        ds_to_es_bus = {f_pc, f_src1, f_src2, f_alu_op, f_rkd, f_ld, f_st, f_rfm, f_gwe,
                        f_dest, f_csr_we, f_csr_rd, f_ertn, f_tid, f_cvl, f_cvh,
                        f_wmask, f_num, f_exc};
    endtask

    // hands one bundle to es; es must be able to accept at the coming edge
    task automatic issue();
        drive_bus();
        ds_to_es_valid = 1'b1;
        tick();
        ds_to_es_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ms_allowin = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
        ms_int = 1'b0; ws_int = 1'b0; ws_reflush_es = 1'b0;
        sram_if.addr_ok = 1'b0;
        clear_fields();
        repeat (3) tick();

        // reset state
        check("rst_ms_valid", 64'(es_to_ms_valid), 64'd0);
        check("rst_req", 64'(sram_if.req), 64'd0);
        check("rst_load", 64'(es_load), 64'd0);
        check("rst_csr", 64'(es_csr), 64'd0);
        check("rst_tid", 64'(es_tid), 64'd0);
        check("rst_fwd_dest", 64'(es_to_ds_dest), 64'd0);
        check("rst_fwd_value", 64'(es_to_ds_value), 64'd0);
        check("rst_allowin", 64'(es_allowin), 64'd1);
        reset = 1'b0;
        tick();

        // ld.w 0x1000 with addr_ok low for three cycles
        clear_fields();
        f_ld = 5'b10000; f_rfm = 1; f_gwe = 1; f_dest = 5'd5;
        f_src1 = 32'h0000_0ff0; f_src2 = 32'h0000_0010;
        issue();
        check("ldw_addr", 64'(sram_if.addr), 64'h1000);
        check("ldw_size", 64'(sram_if.size), 64'd2);
        check("ldw_wr", 64'(sram_if.wr), 64'd0);
        check("ldw_wstrb", 64'(sram_if.wstrb), 64'd0);
        check("ldw_es_load", 64'(es_load), 64'd1);
        check("ldw_fwd_dest", 64'(es_to_ds_dest), 64'd5);
        for (int i = 0; i < 3; i++) begin
            check("ldw_req_wait", 64'(sram_if.req), 64'd1);
            check("ldw_ms_valid_wait", 64'(es_to_ms_valid), 64'd0);
            check("ldw_allowin_wait", 64'(es_allowin), 64'd0);
            tick();
        end
        sram_if.addr_ok = 1'b1;
        #1;
        check("ldw_req_ok", 64'(sram_if.req), 64'd1);
        check("ldw_ms_valid_ok", 64'(es_to_ms_valid), 64'd1);
        check("ldw_res_from_mem", 64'(es_to_ms_bus[70]), 64'd1);
        check("ldw_mem_we", 64'(es_to_ms_bus[143]), 64'd0);
        check("ldw_allowin_ok", 64'(es_allowin), 64'd1);
        tick();
        sram_if.addr_ok = 1'b0;
        #1;
        check("ldw_req_after", 64'(sram_if.req), 64'd0);
        check("ldw_ms_valid_after", 64'(es_to_ms_valid), 64'd0);

        // st.b 0x1003, rkd 0xA5
        clear_fields();
        f_st = 3'b001; f_src1 = 32'h0000_1000; f_src2 = 32'h3; f_rkd = 32'h0000_00a5;
        issue();
        sram_if.addr_ok = 1'b1;
        #1;
        check("stb_wstrb", 64'(sram_if.wstrb), 64'b1000);
        check("stb_wdata", 64'(sram_if.wdata), 64'ha5a5_a5a5);
        check("stb_size", 64'(sram_if.size), 64'd0);
        check("stb_wr", 64'(sram_if.wr), 64'd1);
        check("stb_req", 64'(sram_if.req), 64'd1);
        check("stb_mem_we", 64'(es_to_ms_bus[143]), 64'd1);
        check("stb_ms_valid", 64'(es_to_ms_valid), 64'd1);
        check("stb_fwd_dest", 64'(es_to_ds_dest), 64'd0);
        tick();

        // st.h 0x1002 (aligned upper half)
        clear_fields();
        f_st = 3'b010; f_src1 = 32'h0000_1000; f_src2 = 32'h2; f_rkd = 32'h1234_beef;
        issue();
        check("sth_wstrb", 64'(sram_if.wstrb), 64'b1100);
        check("sth_wdata", 64'(sram_if.wdata), 64'hbeef_beef);
        check("sth_size", 64'(sram_if.size), 64'd1);
        check("sth_req", 64'(sram_if.req), 64'd1);
        tick();

        // st.h 0x1001 raises ALE and never requests
        clear_fields();
        sram_if.addr_ok = 1'b0;
        f_st = 3'b010; f_src1 = 32'h0000_1000; f_src2 = 32'h1; f_rkd = 32'h5555_aaaa;
        issue();
        check("ale_req", 64'(sram_if.req), 64'd0);
        check("ale_cause", 64'(es_to_ms_bus[76 + EXC_ALE]), 64'd1);
        check("ale_mem_we", 64'(es_to_ms_bus[143]), 64'd0);
        check("ale_ms_valid", 64'(es_to_ms_valid), 64'd1);
        tick();
        check("ale_gone", 64'(es_to_ms_valid), 64'd0);

        // ld.hu 0x1002 is aligned: no ALE, half size
        clear_fields();
        sram_if.addr_ok = 1'b1;
        f_ld = 5'b01000; f_rfm = 1; f_gwe = 1; f_dest = 5'd9;
        f_src1 = 32'h0000_1000; f_src2 = 32'h2;
        issue();
        check("ldhu_req", 64'(sram_if.req), 64'd1);
        check("ldhu_no_ale", 64'(es_to_ms_bus[76 + EXC_ALE]), 64'd0);
        check("ldhu_size", 64'(sram_if.size), 64'd1);
        check("ldhu_res_from_mem", 64'(es_to_ms_bus[70]), 64'd1);
        tick();

        // st.w 0x2000 while ms holds an exception
        clear_fields();
        f_st = 3'b100; f_src1 = 32'h0000_2000; f_rkd = 32'hdead_beef;
        issue();
        ms_int = 1'b1;
        #1;
        check("msint_req", 64'(sram_if.req), 64'd0);
        check("msint_mem_we", 64'(es_to_ms_bus[143]), 64'd0);
        check("msint_ms_valid", 64'(es_to_ms_valid), 64'd1);
        tick();
        ms_int = 1'b0;
        sram_if.addr_ok = 1'b0;

        // flush while ld.w 0x3000 waits for addr_ok
        clear_fields();
        f_ld = 5'b10000; f_rfm = 1; f_gwe = 1; f_dest = 5'd3; f_src1 = 32'h0000_3000;
        issue();
        check("flush_req_before", 64'(sram_if.req), 64'd1);
        ws_reflush_es = 1'b1;
        #1;
        check("flush_req_during", 64'(sram_if.req), 64'd0);
        check("flush_ms_valid", 64'(es_to_ms_valid), 64'd0);
        tick();
        ws_reflush_es = 1'b0;
        #1;
        check("flush_es_load", 64'(es_load), 64'd0);
        check("flush_req_after", 64'(sram_if.req), 64'd0);
        tick();
        check("flush_req_later", 64'(sram_if.req), 64'd0);

        // flush and a new bundle in the same cycle: flush wins
        drive_bus();
        ds_to_es_valid = 1'b1;
        ws_reflush_es  = 1'b1;
        tick();
        ds_to_es_valid = 1'b0;
        ws_reflush_es  = 1'b0;
        #1;
        check("flush_vs_valid_load", 64'(es_load), 64'd0);
        check("flush_vs_valid_allowin", 64'(es_allowin), 64'd1);

        // rdcntvl.w / rdcntvh.w against the bench cycle count
        repeat (4) tick();
        clear_fields();
        f_cvl = 1; f_gwe = 1; f_dest = 5'd7; f_csr_rd = 1;
        issue();
        check("cntvl_result", 64'(es_to_ms_bus[63:32]), 64'(cyc[31:0]));
        check("cntvl_fwd_value", 64'(es_to_ds_value), 64'(cyc[31:0]));
        check("cntvl_fwd_dest", 64'(es_to_ds_dest), 64'd7);
        check("cntvl_es_csr", 64'(es_csr), 64'd1);
        check("cntvl_ms_valid", 64'(es_to_ms_valid), 64'd1);
        clear_fields();
        f_cvh = 1; f_gwe = 1; f_dest = 5'd8; f_tid = 1;
        issue();
        check("cntvh_result", 64'(es_to_ms_bus[63:32]), 64'd0);
        check("tid_es_tid", 64'(es_tid), 64'd1);
        check("tid_bus", 64'(es_to_ms_bus[142]), 64'd1);

        // counter preset just below the low-word wrap
        force dut.stable_cnt = 64'h0000_0000_ffff_fffe;
        #2;
        release dut.stable_cnt;
        clear_fields();
        f_cvl = 1; f_gwe = 1; f_dest = 5'd1;
        issue();
        check("wrap_lo_before", 64'(es_to_ms_bus[63:32]), 64'hffff_ffff);
        clear_fields();
        f_cvh = 1; f_gwe = 1; f_dest = 5'd2;
        issue();
        check("wrap_hi_after", 64'(es_to_ms_bus[63:32]), 64'd1);
        clear_fields();
        f_cvl = 1; f_gwe = 1; f_dest = 5'd3;
        issue();
        check("wrap_lo_after", 64'(es_to_ms_bus[63:32]), 64'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
